// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the next-PC predictor: counter states, BTB entry
// kinds and the bundled resolution request from execute.
package branch_predictor_pkg;

    // 2-bit direction counter; bit 1 is the predicted direction.
    typedef enum logic [1:0] {
        BP_SNT = 2'b00,
        BP_WNT = 2'b01,
        BP_WT  = 2'b10,
        BP_ST  = 2'b11
    } bp_cnt_e;

    localparam logic BP_KIND_BRANCH = 1'b0;
    localparam logic BP_KIND_JUMP   = 1'b1;

    // Resolution of one branch/JAL coming back from execute.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
        logic        is_branch;
        logic        is_jump;
    } bp_upd_t;

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state function of a 2-bit saturating direction counter.
module bp_sat_counter
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       taken,
    output logic [1:0] cnt_next
);

    // Step toward the resolved direction, holding at either end.
    always_comb begin
        cnt_next = cnt;
        if (taken) begin
            if (cnt != BP_ST)  cnt_next = cnt + 2'd1;
        end else begin
            if (cnt != BP_SNT) cnt_next = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Next-PC predictor: direct-mapped BTB plus a table of 2-bit counters.
// Lookup is combinational from fetch_pc; training happens on the clock edge
// from execute-stage resolution. Define BP_GSHARE_EN to hash the counter
// index with a global history register; otherwise the counters are bimodal.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int BTB_ENTRIES = 64,
    parameter int GHR_BITS    = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] fetch_pc,
    output logic [31:0] predict_pc,
    output logic        predict_taken,
    output logic        btb_hit,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken,
    input  logic        upd_is_branch,
    input  logic        upd_is_jump
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 32 - IDX_W - 2;

    logic [BTB_ENTRIES-1:0]             btb_valid;
    logic [BTB_ENTRIES-1:0][TAG_W-1:0]  btb_tag;
    logic [BTB_ENTRIES-1:0][31:0]       btb_target;
    logic [BTB_ENTRIES-1:0]             btb_kind;
    logic [BTB_ENTRIES-1:0][1:0]        bht;

    bp_upd_t          upd;
    logic [IDX_W-1:0] f_idx, f_bidx, u_idx, u_bidx;
    logic [TAG_W-1:0] f_tag, u_tag;
    logic             u_hit;
    logic [1:0]       cnt_next;

    assign upd = '{valid: upd_valid, pc: upd_pc, target: upd_target,
                   taken: upd_taken, is_branch: upd_is_branch, is_jump: upd_is_jump};

    assign f_idx = fetch_pc[IDX_W+1:2];
    assign f_tag = fetch_pc[31:IDX_W+2];
    assign u_idx = upd.pc[IDX_W+1:2];
    assign u_tag = upd.pc[31:IDX_W+2];

    // Byte offset within the instruction word never affects prediction.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{fetch_pc[1:0], upd_pc[1:0]};

`ifdef BP_GSHARE_EN
    logic [GHR_BITS-1:0] ghr;

    // Both lookup and update hash with the history as it stands this cycle,
    // so the update side naturally uses the pre-shift value.
    assign f_bidx = f_idx ^ IDX_W'(ghr);
    assign u_bidx = u_idx ^ IDX_W'(ghr);

    // History records the direction of every conditional branch; JAL
    // (including branch+jump, which counts as a jump) leaves it alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ghr <= '0;
        else if (upd.valid && upd.is_branch && !upd.is_jump)
            ghr <= GHR_BITS'({ghr, upd.taken});
    end
`else
    localparam int unused_ghr_bits = GHR_BITS;
    assign f_bidx = f_idx;
    assign u_bidx = u_idx;
`endif

    // Combinational lookup; same-cycle updates are not bypassed.
    always_comb begin
        btb_hit       = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
        predict_taken = btb_hit && (btb_kind[f_idx] || bht[f_bidx][1]);
        predict_pc    = predict_taken ? btb_target[f_idx] : fetch_pc + 32'd4;
    end

    assign u_hit = btb_valid[u_idx] && (btb_tag[u_idx] == u_tag);

    bp_sat_counter u_cnt (
        .cnt      (bht[u_bidx]),
        .taken    (upd.taken),
        .cnt_next (cnt_next)
    );

    // Valid bits and counters: cleared by reset, trained by resolutions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btb_valid <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) bht[i] <= BP_WNT;
        end else if (upd.valid) begin
            if (upd.is_jump) begin
                btb_valid[u_idx] <= 1'b1;
                bht[u_bidx]      <= BP_ST;
            end else if (upd.is_branch) begin
                if (upd.taken && !u_hit) begin
                    btb_valid[u_idx] <= 1'b1;
                    bht[u_bidx]      <= BP_WT;
                end else begin
                    bht[u_bidx]      <= cnt_next;
                end
            end
        end
    end

    // Entry payload needs no reset: it is only observed behind a valid bit,
    // and anything written while reset is held stays invisible.
    always_ff @(posedge clk) begin
        if (upd.valid) begin
            if (upd.is_jump) begin
                btb_tag[u_idx]    <= u_tag;
                btb_target[u_idx] <= upd.target;
                btb_kind[u_idx]   <= BP_KIND_JUMP;
            end else if (upd.is_branch && upd.taken) begin
                btb_target[u_idx] <= upd.target;
                if (!u_hit) begin
                    btb_tag[u_idx]  <= u_tag;
                    btb_kind[u_idx] <= BP_KIND_BRANCH;
                end
            end
        end
    end

endmodule
